// File: rtl/key_ctrl_pkg.sv
// rtl/key_ctrl_pkg.sv - shared event codes and hold FSM states for the key event controller
package key_ctrl_pkg;

    localparam logic [1:0] EVT_PRESS  = 2'd0;
    localparam logic [1:0] EVT_LONG   = 2'd1;
    localparam logic [1:0] EVT_REPEAT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } hold_state_t;

endpackage

// File: rtl/key_event_controller_if.sv
// rtl/key_event_controller_if.sv - key event stream handshake bundle
// master (controller): drives evt_valid, evt_key, evt_type, evt_overrun; samples evt_ready
// slave  (consumer)  : samples the event fields; drives evt_ready
interface key_evt_if #(
    parameter int N_KEYS = 5
);
    localparam int KW = $clog2(N_KEYS);

    logic          evt_valid;
    logic          evt_ready;
    logic [KW-1:0] evt_key;
    logic [1:0]    evt_type;
    logic          evt_overrun;

    modport master (
        output evt_valid, evt_key, evt_type, evt_overrun,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_key, evt_type, evt_overrun,
        output evt_ready
    );
endinterface

// File: rtl/key_event_controller_tick_gen.sv
// rtl/key_event_controller_tick_gen.sv - free-running hold-timer tick divider
// clk, rst_n : clock, synchronous active-low reset
// tick       : one-cycle pulse every TICK_DIV cycles (when count == TICK_DIV-1)
module tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(TICK_DIV - 1));
    assign tick   = w_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/key_event_controller.sv
// rtl/key_event_controller.sv - turns debounced key levels into PRESS/LONG/REPEAT events
// clk, rst_n : clock, synchronous active-low reset
// key_level  : debounced key levels, 1 = pressed
// evt        : event stream (valid/ready, key index, type, overrun pulse)
import key_ctrl_pkg::*;

module key_event_controller #(
    parameter int N_KEYS       = 5,
    parameter int TICK_DIV     = 100000,
    parameter int LONG_TICKS   = 800,
    parameter int REPEAT_TICKS = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_level,
    key_evt_if.master         evt
);
    localparam int KW   = $clog2(N_KEYS);
    localparam int HMAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int HW   = $clog2(HMAX + 1);

    logic [N_KEYS-1:0] r_key_prev, r_pending;
    logic [KW-1:0]     r_rr_ptr, r_key, r_trk;
    logic              r_valid, r_overrun, r_long_pend;
    logic [1:0]        r_type, r_long_type;
    logic [HW-1:0]     r_hc;
    hold_state_t       r_state;

    logic [N_KEYS-1:0] w_rise, w_req, w_gnt_vec, w_pending_n;
    logic [KW:0]       w_scan;
    logic [KW-1:0]     w_gnt_idx, w_trk_n;
    logic              w_found, w_free, w_grant, w_load_long, w_tick, w_lp_n;
    logic [1:0]        w_lt_n;
    logic [HW-1:0]     w_hc_n;
    hold_state_t       w_state_n;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .tick(w_tick));

    // A fresh rise competes in the same cycle as already-pending keys, giving
    // one cycle from rise to evt_valid when the slot is free.
    assign w_rise      = key_level & ~r_key_prev;
    assign w_req       = r_pending | w_rise;
    assign w_free      = ~r_valid | evt.evt_ready;
    assign w_grant     = w_free & w_found;
    assign w_load_long = w_free & ~w_found & r_long_pend;

    // Round-robin scan starting at r_rr_ptr, wrapping N_KEYS-1 -> 0.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int j = 0; j < N_KEYS; j++) begin
            w_scan = {1'b0, r_rr_ptr} + (KW+1)'(j);
            if (w_scan >= (KW+1)'(N_KEYS)) w_scan = w_scan - (KW+1)'(N_KEYS);
            if (!w_found && w_req[w_scan[KW-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_scan[KW-1:0];
            end
        end
    end

    // A granted key keeps its pending bit only if it was already pending and
    // rose again this cycle (a second press queued behind the one just sent).
    always_comb begin
        w_gnt_vec = '0;
        if (w_grant) w_gnt_vec[w_gnt_idx] = 1'b1;
        for (int i = 0; i < N_KEYS; i++) begin
            w_pending_n[i] = w_gnt_vec[i] ? (r_pending[i] & w_rise[i])
                                          : (r_pending[i] | w_rise[i]);
        end
    end

    // Hold FSM next state. A PRESS grant always retracks; release discards any
    // unsent LONG/REPEAT; a threshold hit while long_pend is set just re-arms it.
    always_comb begin
        w_state_n = r_state;
        w_trk_n   = r_trk;
        w_hc_n    = r_hc;
        w_lp_n    = r_long_pend;
        w_lt_n    = r_long_type;
        if (w_load_long) w_lp_n = 1'b0;
        if (w_grant) begin
            w_state_n = ST_HOLD;
            w_trk_n   = w_gnt_idx;
            w_hc_n    = '0;
            w_lp_n    = 1'b0;
        end else begin
            case (r_state)
                ST_HOLD, ST_REPEAT: begin
                    if (!key_level[r_trk]) begin
                        w_state_n = ST_IDLE;
                        w_hc_n    = '0;
                        w_lp_n    = 1'b0;
                    end else if (w_tick) begin
                        if ((r_state == ST_HOLD && r_hc == HW'(LONG_TICKS - 1)) ||
                            (r_state == ST_REPEAT && r_hc == HW'(REPEAT_TICKS - 1))) begin
                            w_lp_n    = 1'b1;
                            w_lt_n    = (r_state == ST_HOLD) ? EVT_LONG : EVT_REPEAT;
                            w_hc_n    = '0;
                            w_state_n = ST_REPEAT;
                        end else begin
                            w_hc_n = r_hc + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_trk       <= '0;
            r_hc        <= '0;
            r_long_pend <= 1'b0;
            r_long_type <= EVT_PRESS;
        end else begin
            r_state     <= w_state_n;
            r_trk       <= w_trk_n;
            r_hc        <= w_hc_n;
            r_long_pend <= w_lp_n;
            r_long_type <= w_lt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key_prev <= '0;
            r_pending  <= '0;
            r_rr_ptr   <= '0;
            r_valid    <= 1'b0;
            r_key      <= '0;
            r_type     <= EVT_PRESS;
            r_overrun  <= 1'b0;
        end else begin
            r_key_prev <= key_level;
            r_pending  <= w_pending_n;
            r_overrun  <= |(w_rise & r_pending & ~w_gnt_vec);
            if (w_grant) begin
                r_rr_ptr <= (w_gnt_idx == KW'(N_KEYS - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
            if (w_free) begin
                if (w_grant) begin
                    r_valid <= 1'b1;
                    r_key   <= w_gnt_idx;
                    r_type  <= EVT_PRESS;
                end else if (r_long_pend) begin
                    r_valid <= 1'b1;
                    r_key   <= r_trk;
                    r_type  <= r_long_type;
                end else begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign evt.evt_valid   = r_valid;
    assign evt.evt_key     = r_key;
    assign evt.evt_type    = r_type;
    assign evt.evt_overrun = r_overrun;
endmodule

// File: tb/tb_key_event_controller.sv
// tb/tb_key_event_controller.sv - self-checking bench for key_event_controller
module tb_key_event_controller;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] key_level;

    key_evt_if #(.N_KEYS(5)) evt_if ();

    key_event_controller #(
        .N_KEYS(5), .TICK_DIV(4), .LONG_TICKS(3), .REPEAT_TICKS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_level(key_level), .evt(evt_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] kl;
        logic       rdy;
        logic       v;
        logic [2:0] k;
        logic [1:0] t;
        logic       ov;
    } vec_t;

    typedef struct {
        logic [2:0] k;
        logic [1:0] t;
        int         cyc;
    } ev_t;

    vec_t tbl[19];
    ev_t  evq[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n === 1'b1 && evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1)
            evq.push_back('{evt_if.evt_key, evt_if.evt_type, cyc});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        key_level = '0;
        evt_if.evt_ready = 1'b1;
        repeat (3) step();
        chk("reset_valid", 32'(evt_if.evt_valid), 0);
        chk("reset_key", 32'(evt_if.evt_key), 0);
        chk("reset_type", 32'(evt_if.evt_type), 0);
        chk("reset_overrun", 32'(evt_if.evt_overrun), 0);
        rst_n = 1'b1;

        //            kl        rdy   v     k     t     ov
        tbl[0]  = '{5'b00000, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[1]  = '{5'b00100, 1'b1, 1'b1, 3'd2, 2'd0, 1'b0};
        tbl[2]  = '{5'b00100, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[3]  = '{5'b00000, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[4]  = '{5'b00001, 1'b1, 1'b1, 3'd0, 2'd0, 1'b0};
        tbl[5]  = '{5'b00000, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[6]  = '{5'b10011, 1'b1, 1'b1, 3'd1, 2'd0, 1'b0};
        tbl[7]  = '{5'b10011, 1'b1, 1'b1, 3'd4, 2'd0, 1'b0};
        tbl[8]  = '{5'b10011, 1'b1, 1'b1, 3'd0, 2'd0, 1'b0};
        tbl[9]  = '{5'b00000, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[10] = '{5'b01000, 1'b0, 1'b1, 3'd3, 2'd0, 1'b0};
        tbl[11] = '{5'b00000, 1'b0, 1'b1, 3'd3, 2'd0, 1'b0};
        tbl[12] = '{5'b01000, 1'b0, 1'b1, 3'd3, 2'd0, 1'b0};
        tbl[13] = '{5'b00000, 1'b0, 1'b1, 3'd3, 2'd0, 1'b0};
        tbl[14] = '{5'b01000, 1'b0, 1'b1, 3'd3, 2'd0, 1'b1};
        tbl[15] = '{5'b01000, 1'b0, 1'b1, 3'd3, 2'd0, 1'b0};
        tbl[16] = '{5'b00000, 1'b1, 1'b1, 3'd3, 2'd0, 1'b0};
        tbl[17] = '{5'b00000, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[18] = '{5'b00000, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};

        for (int i = 0; i < 19; i++) begin
            key_level = tbl[i].kl;
            evt_if.evt_ready = tbl[i].rdy;
            step();
            chk($sformatf("row%0d_valid", i), 32'(evt_if.evt_valid), 32'(tbl[i].v));
            chk($sformatf("row%0d_overrun", i), 32'(evt_if.evt_overrun), 32'(tbl[i].ov));
            if (tbl[i].v) begin
                chk($sformatf("row%0d_key", i), 32'(evt_if.evt_key), 32'(tbl[i].k));
                chk($sformatf("row%0d_type", i), 32'(evt_if.evt_type), 32'(tbl[i].t));
            end
        end

        // Hold key 0 for 40 cycles: PRESS, LONG 10..13 cycles later, REPEAT every 8.
        evq.delete();
        evt_if.evt_ready = 1'b1;
        key_level = 5'b00001;
        repeat (40) step();
        key_level = 5'b00000;
        repeat (30) step();
        chk("hold_count", 32'(evq.size()), 5);
        if (evq.size() == 5) begin
            chk("hold_press_key", 32'(evq[0].k), 0);
            chk("hold_press_type", 32'(evq[0].t), 0);
            chk("hold_long_type", 32'(evq[1].t), 1);
            chk("hold_long_key", 32'(evq[1].k), 0);
            chk("hold_long_gap_ok", 32'((evq[1].cyc - evq[0].cyc >= 10) &&
                                        (evq[1].cyc - evq[0].cyc <= 13)), 1);
            for (int r = 2; r < 5; r++) begin
                chk($sformatf("hold_rep%0d_type", r), 32'(evq[r].t), 2);
                chk($sformatf("hold_rep%0d_gap", r), 32'(evq[r].cyc - evq[r-1].cyc), 8);
            end
        end

        // LONG/REPEAT pending behind a stalled PRESS is discarded on release.
        evq.delete();
        evt_if.evt_ready = 1'b0;
        key_level = 5'b00001;
        repeat (20) step();
        chk("race_valid_held", 32'(evt_if.evt_valid), 1);
        chk("race_key_held", 32'(evt_if.evt_key), 0);
        chk("race_type_held", 32'(evt_if.evt_type), 0);
        key_level = 5'b00000;
        repeat (3) step();
        evt_if.evt_ready = 1'b1;
        repeat (30) step();
        chk("race_count", 32'(evq.size()), 1);
        if (evq.size() == 1) chk("race_only_press", 32'(evq[0].t), 0);

        // Reset while an event is held and keys 1,2 are pending.
        evq.delete();
        evt_if.evt_ready = 1'b0;
        key_level = 5'b01000;
        step();
        key_level = 5'b01110;
        step();
        chk("rst_pre_valid", 32'(evt_if.evt_valid), 1);
        chk("rst_pre_key", 32'(evt_if.evt_key), 3);
        rst_n = 1'b0;
        key_level = 5'b00000;
        step();
        chk("rst_mid_valid", 32'(evt_if.evt_valid), 0);
        chk("rst_mid_key", 32'(evt_if.evt_key), 0);
        chk("rst_mid_type", 32'(evt_if.evt_type), 0);
        chk("rst_mid_overrun", 32'(evt_if.evt_overrun), 0);
        rst_n = 1'b1;
        evt_if.evt_ready = 1'b1;
        repeat (20) step();
        chk("rst_no_events", 32'(evq.size()), 0);
        key_level = 5'b00010;
        step();
        chk("rst_new_valid", 32'(evt_if.evt_valid), 1);
        chk("rst_new_key", 32'(evt_if.evt_key), 1);
        chk("rst_new_type", 32'(evt_if.evt_type), 0);
        key_level = 5'b00000;
        repeat (5) step();
        chk("rst_new_count", 32'(evq.size()), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
